rx_byte_aligner: RTL and testbench



---
 rtl/rx_byte_aligner.sv | 207 ++++++++++++++++++++
 tb/tb_rx_byte_aligner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_aligner.sv
// Restores 16-bit word alignment behind a GT receiver whose comma aligner may
// lock the K28.5 comma into the low byte; selects straight or byte-swapped assembly.
module rx_byte_aligner #(
   parameter logic [7:0] g_COMMA         = 8'hBC,
   parameter int         g_LOCK_COUNT    = 4,
   parameter int         g_LOSS_COUNT    = 3,
   parameter int         g_COMMA_TIMEOUT = 1024
) (
   input  logic        usrclk_i,
   input  logic        rst_n_i,
   input  logic [15:0] rx_data_i,
   input  logic [1:0]  rx_k_i,
   input  logic        realign_i,
   output logic [15:0] rx_data_o,
   output logic [1:0]  rx_k_o,
   output logic        aligned_o,
   output logic        shifted_o,
   output logic [7:0]  loss_count_o
);

   localparam int LCW = $clog2(g_LOCK_COUNT + 1);
   localparam int ECW = $clog2(g_LOSS_COUNT + 1);

   localparam logic [LCW-1:0] LOCK_LAST = LCW'(g_LOCK_COUNT);
   localparam logic [ECW-1:0] LOSS_LAST = ECW'(g_LOSS_COUNT);
   localparam logic [15:0]    TMO_LAST  = 16'(g_COMMA_TIMEOUT - 1);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   function automatic logic is_comma(input logic [7:0] b, input logic k);
      return k && (b == g_COMMA);
   endfunction

   logic [15:0]    s1_data_q, s1_data_d;
   logic [1:0]     s1_k_q, s1_k_d;
   logic [15:0]    out_data_q, out_data_d;
   logic [1:0]     out_k_q, out_k_d;
   logic [1:0]     state_q, state_d;
   logic           shifted_q, shifted_d;
   logic           aligned_q, aligned_d;
   logic [LCW-1:0] good_cnt_q, good_cnt_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;
   logic [15:0]    tmo_cnt_q, tmo_cnt_d;
   logic [7:0]     loss_cnt_q, loss_cnt_d;

   logic           comma_hi_s, comma_lo_s, any_comma_s, single_s;
   logic           good_pos_s, wrong_pos_s, timeout_s, leave_lock_s;
   logic [LCW-1:0] good_inc_s;
   logic [ECW-1:0] err_inc_s;

   // Comma classification against the currently selected byte position.
   always_comb begin
      comma_hi_s  = is_comma(rx_data_i[15:8], rx_k_i[1]);
      comma_lo_s  = is_comma(rx_data_i[7:0], rx_k_i[0]);
      any_comma_s = comma_hi_s | comma_lo_s;
      single_s    = comma_hi_s ^ comma_lo_s;
      good_pos_s  = single_s & (shifted_q ? comma_lo_s : comma_hi_s);
      wrong_pos_s = any_comma_s & ~good_pos_s;
      timeout_s   = (tmo_cnt_q == TMO_LAST) & ~any_comma_s;
      good_inc_s  = good_cnt_q + LCW'(1);
      err_inc_s   = err_cnt_q + ECW'(1);
   end

   // Two-stage datapath; swapped mode borrows the high byte of the following word.
   always_comb begin
      s1_data_d = rx_data_i;
      s1_k_d    = rx_k_i;
      if (shifted_q) begin
         out_data_d = {s1_data_q[7:0], rx_data_i[15:8]};
         out_k_d    = {s1_k_q[0], rx_k_i[1]};
      end else begin
         out_data_d = s1_data_q;
         out_k_d    = s1_k_q;
      end
   end

   // Comma watchdog: held at zero while hunting, restarted by any comma.
   always_comb begin
      if ((state_q == ST_HUNT) || any_comma_s) begin
         tmo_cnt_d = 16'd0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
   end

   // Alignment FSM; realign_i overrides everything including a same-cycle comma.
   always_comb begin
      state_d      = state_q;
      shifted_d    = shifted_q;
      good_cnt_d   = good_cnt_q;
      err_cnt_d    = err_cnt_q;
      leave_lock_s = 1'b0;
      if (realign_i) begin
         state_d      = ST_HUNT;
         good_cnt_d   = '0;
         err_cnt_d    = '0;
         leave_lock_s = (state_q == ST_LOCKED);
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (single_s) begin
                  shifted_d  = comma_lo_s;
                  good_cnt_d = LCW'(1);
                  err_cnt_d  = '0;
                  if (LOCK_LAST == LCW'(1)) begin
                     state_d = ST_LOCKED;
                  end else begin
                     state_d = ST_VERIFY;
                  end
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_VERIFY: begin
               if (good_pos_s) begin
                  good_cnt_d = good_inc_s;
                  if (good_inc_s == LOCK_LAST) begin
                     state_d   = ST_LOCKED;
                     err_cnt_d = '0;
                  end else begin
                     state_d = ST_VERIFY;
                  end
               end else if (wrong_pos_s || timeout_s) begin
                  state_d    = ST_HUNT;
                  good_cnt_d = '0;
               end else begin
                  state_d = ST_VERIFY;
               end
            end
            ST_LOCKED: begin
               if (good_pos_s) begin
                  err_cnt_d = '0;
               end else if (wrong_pos_s) begin
                  if (err_inc_s == LOSS_LAST) begin
                     state_d      = ST_HUNT;
                     err_cnt_d    = '0;
                     good_cnt_d   = '0;
                     leave_lock_s = 1'b1;
                  end else begin
                     err_cnt_d = err_inc_s;
                  end
               end else if (timeout_s) begin
                  state_d      = ST_HUNT;
                  err_cnt_d    = '0;
                  good_cnt_d   = '0;
                  leave_lock_s = 1'b1;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
            default: begin
               state_d    = ST_HUNT;
               good_cnt_d = '0;
               err_cnt_d  = '0;
            end
         endcase
      end
   end

   // Saturating loss-of-lock counter and registered lock flag.
   always_comb begin
      if (leave_lock_s && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_d = loss_cnt_q + 8'd1;
      end else begin
         loss_cnt_d = loss_cnt_q;
      end
      aligned_d = (state_d == ST_LOCKED);
   end

   // State and pipeline registers.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_data_q  <= 16'd0;
         s1_k_q     <= 2'd0;
         out_data_q <= 16'd0;
         out_k_q    <= 2'd0;
         state_q    <= ST_HUNT;
         shifted_q  <= 1'b0;
         aligned_q  <= 1'b0;
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
         tmo_cnt_q  <= 16'd0;
         loss_cnt_q <= 8'd0;
      end else begin
         s1_data_q  <= s1_data_d;
         s1_k_q     <= s1_k_d;
         out_data_q <= out_data_d;
         out_k_q    <= out_k_d;
         state_q    <= state_d;
         shifted_q  <= shifted_d;
         aligned_q  <= aligned_d;
         good_cnt_q <= good_cnt_d;
         err_cnt_q  <= err_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign rx_data_o    = out_data_q;
   assign rx_k_o       = out_k_q;
   assign aligned_o    = aligned_q;
   assign shifted_o    = shifted_q;
   assign loss_count_o = loss_cnt_q;

endmodule

// File: tb/tb_rx_byte_aligner.sv
// Randomized self-checking bench for rx_byte_aligner against a cycle-level
// behavioural model of the lock rules and the byte-reassembly datapath.
module tb_rx_byte_aligner;

   localparam int LOCK = 4;
   localparam int LOSS = 3;
   localparam int TMO  = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rx_data_i;
   logic [1:0]  rx_k_i;
   logic        realign_i;
   logic [15:0] rx_data_o;
   logic [1:0]  rx_k_o;
   logic        aligned_o;
   logic        shifted_o;
   logic [7:0]  loss_count_o;

   rx_byte_aligner #(
      .g_COMMA(8'hBC), .g_LOCK_COUNT(LOCK), .g_LOSS_COUNT(LOSS), .g_COMMA_TIMEOUT(TMO)
   ) dut (
      .usrclk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data_i), .rx_k_i(rx_k_i),
      .realign_i(realign_i), .rx_data_o(rx_data_o), .rx_k_o(rx_k_o),
      .aligned_o(aligned_o), .shifted_o(shifted_o), .loss_count_o(loss_count_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Model: 0 = hunting, 1 = verifying, 2 = locked
   int          m_mode, m_good, m_err, m_quiet, m_loss;
   bit          m_shift;
   logic [15:0] m_prev_word, m_out;
   logic [1:0]  m_prev_k, m_out_k;

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_err = 0; m_quiet = 0; m_loss = 0; m_shift = 1'b0;
      m_prev_word = 16'd0; m_prev_k = 2'd0; m_out = 16'd0; m_out_k = 2'd0;
   endtask

   task automatic lost_lock();
      m_mode = 0;
      if (m_loss < 255) m_loss++;
   endtask

   task automatic model_step(input logic [15:0] d, input logic [1:0] k, input bit rl);
      bit hi, lo, any, good, wrong, tmo;
      hi    = k[1] && (d[15:8] == 8'hBC);
      lo    = k[0] && (d[7:0] == 8'hBC);
      any   = hi || lo;
      good  = (hi != lo) && (m_shift ? lo : hi);
      wrong = any && !good;
      if (m_shift) begin
         m_out = {m_prev_word[7:0], d[15:8]}; m_out_k = {m_prev_k[0], k[1]};
      end else begin
         m_out = m_prev_word; m_out_k = m_prev_k;
      end
      m_prev_word = d; m_prev_k = k;
      if (rl) begin
         if (m_mode == 2) lost_lock();
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (hi != lo) begin
            m_shift = lo; m_good = 1; m_err = 0;
            m_mode = (m_good >= LOCK) ? 2 : 1;
         end
      end else begin
         m_quiet = any ? 0 : m_quiet + 1;
         tmo = (m_quiet == TMO);
         if (m_mode == 1) begin
            if (good) begin
               m_good++;
               if (m_good == LOCK) begin m_mode = 2; m_err = 0; end
            end else if (wrong || tmo) m_mode = 0;
         end else begin
            if (good) m_err = 0;
            else if (wrong) begin
               m_err++;
               if (m_err == LOSS) lost_lock();
            end else if (tmo) lost_lock();
         end
      end
      if (m_mode == 0) m_quiet = 0;
   endtask

   task automatic cycle(input logic [15:0] d, input logic [1:0] k, input bit rl);
      rx_data_i = d; rx_k_i = k; realign_i = rl;
      @(posedge clk);
      model_step(d, k, rl);
      #1;
      check("data", rx_data_o, m_out);
      check("k", rx_k_o, m_out_k);
      check("aligned", aligned_o, m_mode == 2);
      check("shifted", shifted_o, m_shift);
      check("loss", loss_count_o, m_loss);
      realign_i = 1'b0;
   endtask

   // Byte-stream generator; a pending byte shifts the comma into the low byte
   logic [7:0]  pend_b;
   logic        pend_k;
   bit          have_pend;
   logic [15:0] pay_cnt;

   task automatic put_byte(input logic [7:0] b, input logic kb);
      if (!have_pend) begin
         pend_b = b; pend_k = kb; have_pend = 1'b1;
      end else begin
         cycle({pend_b, b}, {pend_k, kb}, 1'b0);
         have_pend = 1'b0;
      end
   endtask

   task automatic align_to(input bit odd);
      if (have_pend != odd) put_byte(8'($urandom), 1'b0);
   endtask

   task automatic frame(input int period);
      put_byte(8'hBC, 1'b1);
      put_byte(8'h95, 1'b0);
      for (int i = 1; i < period; i++) begin
         put_byte(pay_cnt[15:8], 1'b0);
         put_byte(pay_cnt[7:0], 1'b0);
         pay_cnt++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(16'($urandom), 2'b00, 1'b0);
   endtask

   task automatic hi_c();
      cycle({8'hBC, 8'($urandom)}, 2'b10, 1'b0);
   endtask

   task automatic lo_c();
      cycle({8'($urandom), 8'hBC}, 2'b01, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; rx_data_i = 16'd0; rx_k_i = 2'd0; realign_i = 1'b0;
      have_pend = 1'b0; pay_cnt = 16'd0; pend_b = 8'd0; pend_k = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("rst_data", rx_data_o, 16'd0);
      check("rst_k", rx_k_o, 2'd0);
      check("rst_aligned", aligned_o, 1'b0);
      check("rst_shifted", shifted_o, 1'b0);
      check("rst_loss", loss_count_o, 8'd0);
      @(negedge clk) rst_n = 1'b1;

      // straight stream
      repeat (3) frame(193);
      check("straight_prelock", aligned_o, 1'b0);
      frame(193);
      check("straight_lock", aligned_o, 1'b1);
      check("straight_sel", shifted_o, 1'b0);

      // three wrong-byte commas drop lock, then re-lock on the low byte
      idle(5); lo_c(); idle(3); lo_c(); idle(3);
      check("loss_hold2", aligned_o, 1'b1);
      lo_c();
      check("loss_drop", aligned_o, 1'b0);
      check("loss_cnt1", loss_count_o, 8'd1);
      for (int i = 0; i < 4; i++) begin
         idle(4); lo_c();
         if (i == 2) check("relock_early", aligned_o, 1'b0);
      end
      check("relock", aligned_o, 1'b1);
      check("relock_sel", shifted_o, 1'b1);
      idle(3); hi_c(); idle(3); hi_c(); idle(3); lo_c(); idle(2);
      check("two_wrong_held", aligned_o, 1'b1);
      check("two_wrong_loss", loss_count_o, 8'd1);

      // asynchronous reset mid-stream
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_data", rx_data_o, 16'd0);
      check("arst_k", rx_k_o, 2'd0);
      check("arst_aligned", aligned_o, 1'b0);
      check("arst_shifted", shifted_o, 1'b0);
      check("arst_loss", loss_count_o, 8'd0);
      model_reset();
      have_pend = 1'b0;
      @(negedge clk) rst_n = 1'b1;

      // byte-swapped stream
      align_to(1'b1);
      repeat (3) frame(193);
      check("swap_prelock", aligned_o, 1'b0);
      frame(193);
      check("swap_lock", aligned_o, 1'b1);
      check("swap_sel", shifted_o, 1'b1);
      frame(193);

      // realign coincident with a good comma while locked
      align_to(1'b0);
      idle(2);
      cycle({8'($urandom), 8'hBC}, 2'b01, 1'b1);
      check("realign_drop", aligned_o, 1'b0);
      check("realign_loss", loss_count_o, 8'd1);
      for (int i = 0; i < 3; i++) begin idle(2); lo_c(); end
      check("realign_not_captured", aligned_o, 1'b0);
      cycle(16'($urandom), 2'b00, 1'b1);
      check("realign_verify_noloss", loss_count_o, 8'd1);

      // verify abort keeps selection and needs fresh commas
      idle(2); hi_c(); idle(2); hi_c(); idle(2); lo_c();
      check("abort_aligned", aligned_o, 1'b0);
      check("abort_sel", shifted_o, 1'b0);
      for (int i = 0; i < 3; i++) begin idle(2); hi_c(); end
      check("abort_fresh3", aligned_o, 1'b0);
      idle(2); hi_c();
      check("abort_lock", aligned_o, 1'b1);

      // comma timeout
      idle(5); hi_c();
      for (int i = 1; i <= TMO; i++) begin
         idle(1);
         if (i == TMO - 1) check("tmo_before", aligned_o, 1'b1);
         if (i == TMO) check("tmo_fire", aligned_o, 1'b0);
      end
      check("tmo_loss", loss_count_o, 8'd2);
      for (int i = 0; i < 4; i++) begin idle(3); hi_c(); end
      idle(TMO - 2); hi_c();
      idle(1000);
      check("tmo_kept", aligned_o, 1'b1);
      idle(30);
      check("tmo_second", aligned_o, 1'b0);
      check("tmo_loss3", loss_count_o, 8'd3);

      // loss counter saturation
      for (int i = 0; i < 260; i++) begin
         repeat (4) hi_c();
         cycle(16'($urandom), 2'b00, 1'b1);
      end
      check("loss_saturate", loss_count_o, 8'd255);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         int  r;
         bit  pref;
         pref = ((i / 500) % 2) == 1;
         r = $urandom_range(0, 99);
         if (r < 10) begin
            if (pref) lo_c(); else hi_c();
         end else if (r < 12) begin
            if (pref) hi_c(); else lo_c();
         end else if (r == 12) cycle(16'hBCBC, 2'b11, 1'b0);
         else if (r == 13) cycle(16'($urandom), 2'($urandom), 1'b1);
         else cycle(16'($urandom), 2'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
